// File: rtl/tx_deserializer.sv
// Assembles 4-word framed 32-bit input into 128-bit transactions and spaces output pulses by MIN_GAP.
// Optional framing-error counter enabled by defining TX_DESER_ERR_CNT_EN.
//
// state   | meaning
// COLLECT | accepting words of a frame (s_ready = 1)
// HOLD    | complete frame pending until the gap check passes (s_ready = 0)
// DROP    | discarding the tail of an over-long frame up to s_last (s_ready = 1)
module tx_deserializer #(
  parameter int unsigned MIN_GAP = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic         s_last,
  output logic         o_valid,
  output logic [127:0] o_transaction,
  output logic [15:0]  o_err_cnt
);

  typedef enum logic [1:0] {COLLECT, HOLD, DROP} state_t;

  localparam logic [7:0] GAP_THR = 8'(MIN_GAP - 1);

  state_t       state_q, state_d;
  logic [1:0]   idx_q, idx_d;
  logic [95:0]  part_q, part_d;
  logic [31:0]  pend_q, pend_d;
  logic [127:0] out_q, out_d;
  logic         valid_q, valid_d;
  logic [7:0]   gap_q, gap_d;
  logic         ready_q;
  logic         xfer;
  logic         gap_ok;

  assign xfer          = s_valid && ready_q;
  assign gap_ok        = (gap_q >= GAP_THR);
  assign s_ready       = ready_q;
  assign o_valid       = valid_q;
  assign o_transaction = out_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    part_d  = part_q;
    pend_d  = pend_q;
    out_d   = out_q;
    valid_d = 1'b0;
    case (state_q)
      COLLECT: begin
        if (xfer) begin
          if (idx_q != 2'd3) begin
            if (s_last) begin
              idx_d = 2'd0;
            end else begin
              // shift-in keeps word 0 in the MSBs once three words are held
              part_d = {part_q[63:0], s_data};
              idx_d  = idx_q + 2'd1;
            end
          end else begin
            idx_d = 2'd0;
            if (s_last) begin
              if (gap_ok) begin
                out_d   = {part_q, s_data};
                valid_d = 1'b1;
              end else begin
                pend_d  = s_data;
                state_d = HOLD;
              end
            end else begin
              state_d = DROP;
            end
          end
        end
      end
      HOLD: begin
        if (gap_ok) begin
          out_d   = {part_q, pend_q};
          valid_d = 1'b1;
          state_d = COLLECT;
        end
      end
      DROP: begin
        if (xfer && s_last) begin
          state_d = COLLECT;
          idx_d   = 2'd0;
        end
      end
      default: begin
        state_d = COLLECT;
        idx_d   = 2'd0;
      end
    endcase
  end

  always_comb begin
    if (valid_d)
      gap_d = 8'd0;
    else if (gap_q == 8'hFF)
      gap_d = gap_q;
    else
      gap_d = gap_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= COLLECT;
      idx_q   <= 2'd0;
      part_q  <= '0;
      pend_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      gap_q   <= 8'hFF;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      part_q  <= part_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      gap_q   <= gap_d;
      // registered from next state so it never depends combinationally on s_valid
      ready_q <= (state_d != HOLD);
    end
  end

`ifdef TX_DESER_ERR_CNT_EN
  logic        err_inc;
  logic [15:0] err_q;

  assign err_inc = xfer && (state_q == COLLECT) &&
                   (((idx_q != 2'd3) && s_last) || ((idx_q == 2'd3) && !s_last));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      err_q <= 16'd0;
    else if (err_inc && (err_q != 16'hFFFF))
      err_q <= err_q + 16'd1;
  end

  assign o_err_cnt = err_q;
`else
  assign o_err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_tx_deserializer.sv
// Directed self-checking bench for tx_deserializer with MIN_GAP = 8.
// Saturation test runs only when TX_DESER_ERR_CNT_EN is defined.
module tb_tx_deserializer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [31:0]  s_data = '0;
  logic         s_last = 1'b0;
  logic         o_valid;
  logic [127:0] o_transaction;
  logic [15:0]  o_err_cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pulse_cyc[$];
  logic [127:0] pulse_tr[$];
  int base;
  logic [15:0] exp_err1, exp_err2;

  tx_deserializer #(.MIN_GAP(8)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .o_valid(o_valid),
    .o_transaction(o_transaction), .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (o_valid) begin
      pulse_cyc.push_back(cyc);
      pulse_tr.push_back(o_transaction);
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    int waitc;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    waitc   = 0;
    while (!s_ready && waitc < 50) begin
      @(posedge clk);
      #1;
      waitc++;
    end
    if (!s_ready) check("send_timeout", 128'(s_ready), 128'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] w0, w1, w2, w3);
    send_word(w0, 1'b0);
    send_word(w1, 1'b0);
    send_word(w2, 1'b0);
    send_word(w3, 1'b1);
  endtask

  initial begin
`ifdef TX_DESER_ERR_CNT_EN
    exp_err1 = 16'd1;
    exp_err2 = 16'd2;
`else
    exp_err1 = 16'd0;
    exp_err2 = 16'd0;
`endif
    // reset state
    tick(2);
    check("rst_s_ready", 128'(s_ready), 128'd0);
    check("rst_o_valid", 128'(o_valid), 128'd0);
    check("rst_o_tr", o_transaction, 128'd0);
    check("rst_err", 128'(o_err_cnt), 128'd0);
    rst = 1'b1;
    tick(1);
    check("ready_after_rel", 128'(s_ready), 128'd1);

    // single frame, one-cycle latency
    send_frame(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    check("single_valid", 128'(o_valid), 128'd1);
    check("single_tr", o_transaction, 128'h11111111_22222222_33333333_44444444);
    tick(1);
    check("single_pulse_end", 128'(o_valid), 128'd0);
    check("single_tr_held", o_transaction, 128'h11111111_22222222_33333333_44444444);

    // rate limiting: three back-to-back frames
    tick(20);
    base = pulse_cyc.size();
    send_frame(32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404);
    send_frame(32'h05050505, 32'h06060606, 32'h07070707, 32'h08080808);
    check("hold_ready_low", 128'(s_ready), 128'd0);
    check("hold_no_pulse", 128'(o_valid), 128'd0);
    send_frame(32'h09090909, 32'h0a0a0a0a, 32'h0b0b0b0b, 32'h0c0c0c0c);
    tick(20);
    check("rate_pulses", 128'(pulse_cyc.size() - base), 128'd3);
    if (pulse_cyc.size() >= base + 3) begin
      check("rate_gap12", 128'(pulse_cyc[base+1] - pulse_cyc[base]), 128'd8);
      check("rate_gap23", 128'(pulse_cyc[base+2] - pulse_cyc[base+1]), 128'd8);
      check("rate_tr1", pulse_tr[base],   128'h01010101_02020202_03030303_04040404);
      check("rate_tr2", pulse_tr[base+1], 128'h05050505_06060606_07070707_08080808);
      check("rate_tr3", pulse_tr[base+2], 128'h09090909_0a0a0a0a_0b0b0b0b_0c0c0c0c);
    end

    // short frame then legal frame
    base = pulse_cyc.size();
    send_word(32'hdead0001, 1'b0);
    send_word(32'hdead0002, 1'b1);
    send_frame(32'haaaaaaaa, 32'hbbbbbbbb, 32'hcccccccc, 32'hdddddddd);
    tick(20);
    check("short_pulses", 128'(pulse_cyc.size() - base), 128'd1);
    if (pulse_cyc.size() > base)
      check("short_tr", pulse_tr[base], 128'haaaaaaaa_bbbbbbbb_cccccccc_dddddddd);
    check("short_err", 128'(o_err_cnt), 128'(exp_err1));

    // long frame (6 words) then legal frame
    base = pulse_cyc.size();
    for (int k = 0; k < 6; k++)
      send_word(32'hbad00000 + 32'(k), (k == 5));
    send_frame(32'h12345678, 32'h9abcdef0, 32'h0fedcba9, 32'h87654321);
    tick(20);
    check("long_pulses", 128'(pulse_cyc.size() - base), 128'd1);
    if (pulse_cyc.size() > base)
      check("long_tr", pulse_tr[base], 128'h12345678_9abcdef0_0fedcba9_87654321);
    check("long_err", 128'(o_err_cnt), 128'(exp_err2));

    // reset while a frame is held
    base = pulse_cyc.size();
    send_frame(32'h50505050, 32'h51515151, 32'h52525252, 32'h53535353);
    send_frame(32'h60606060, 32'h61616161, 32'h62626262, 32'h63636363);
    check("rsthold_pending", 128'(s_ready), 128'd0);
    rst = 1'b0;
    #1;
    check("rsthold_valid", 128'(o_valid), 128'd0);
    check("rsthold_tr", o_transaction, 128'd0);
    check("rsthold_ready", 128'(s_ready), 128'd0);
    check("rsthold_err", 128'(o_err_cnt), 128'd0);
    tick(12);
    check("rsthold_lost", 128'(pulse_cyc.size() - base), 128'd1);
    rst = 1'b1;
    send_frame(32'h70707070, 32'h71717171, 32'h72727272, 32'h73737373);
    check("post_rst_valid", 128'(o_valid), 128'd1);
    check("post_rst_tr", o_transaction, 128'h70707070_71717171_72727272_73737373);

`ifdef TX_DESER_ERR_CNT_EN
    // saturation: single-word frames are short frames
    tick(2);
    s_valid = 1'b1;
    s_last  = 1'b1;
    s_data  = 32'h0;
    tick(65537);
    s_valid = 1'b0;
    s_last  = 1'b0;
    tick(2);
    check("err_saturate", 128'(o_err_cnt), 128'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
